// File: rtl/ww_mlp_pkg.sv
// Shared widths, trained weight set and FSM encoding for the white-wine MLP regressor.
package ww_mlp_pkg;

    localparam int WIDTH_A  = 4;
    localparam int NUM_A    = 11;
    localparam int N_HID    = 3;
    localparam int W_W      = 8;
    localparam int HID_W    = 16;
    localparam int H_SHIFT  = 4;
    localparam int OUTWIDTH = 21;

    localparam int BH_W    = 16;
    localparam int BO_W    = 16;
    localparam int ACC_H_W = 24;
    localparam int ACC_O_W = 32;
    localparam int IDX_W   = $clog2(NUM_A);

    typedef logic [N_HID-1:0][NUM_A-1:0][W_W-1:0] w_ih_t;
    typedef logic [N_HID-1:0][BH_W-1:0]           b_h_t;
    typedef logic [N_HID-1:0][W_W-1:0]            w_ho_t;
    typedef logic [BO_W-1:0]                      b_o_t;

    typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_e;

    // Concatenations run from the highest index down: neuron 2 first, feature 10 first.
    localparam w_ih_t W_IH = {
        8'sd14,  -8'sd9,   8'sd22,  8'sd5,  -8'sd17,  8'sd31,  8'sd8,  -8'sd4,   8'sd19, -8'sd12,  8'sd27,
        -8'sd21,  8'sd16,  -8'sd6,   8'sd35,  8'sd11, -8'sd28,  8'sd3,   8'sd24, -8'sd15,  8'sd9,   8'sd13,
        8'sd7,    8'sd29,  -8'sd18, -8'sd10,  8'sd25,  8'sd6,  -8'sd33,  8'sd12,  8'sd20, -8'sd5,   8'sd17
    };
    localparam b_h_t  B_H  = {16'sd200, -16'sd120, 16'sd40};
    localparam w_ho_t W_HO = {8'sd45, -8'sd38, 8'sd61};
    localparam b_o_t  B_O  = 16'sd12000;

endpackage

// File: rtl/ww_mlp_regressor_if.sv
// Request/response bundle between a feature source and the MLP regressor core.
interface ww_mlp_regressor_if;
    import ww_mlp_pkg::*;

    logic                     in_valid;
    logic [NUM_A*WIDTH_A-1:0] inp;
    logic                     busy;
    logic                     out_valid;
    logic [OUTWIDTH-1:0]      out;

    modport master (output in_valid, inp, input busy, out_valid, out);
    modport slave  (input in_valid, inp, output busy, out_valid, out);

endinterface

// File: rtl/ww_mlp_mac.sv
// Signed multiply-accumulate; load_i preloads the accumulator (bias), en_i adds a_i*b_i.
module ww_mlp_mac #(
    parameter int A_W   = 8,
    parameter int B_W   = 5,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic signed [ACC_W-1:0] load_val_i,
    input  logic                    en_i,
    input  logic signed [A_W-1:0]   a_i,
    input  logic signed [B_W-1:0]   b_i,
    output logic signed [ACC_W-1:0] acc_o
);

    logic signed [A_W+B_W-1:0] prod;
    logic signed [ACC_W-1:0]   acc_q, acc_d;

    assign prod  = a_i * b_i;
    assign acc_o = acc_q;

    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = load_val_i;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

endmodule

// File: rtl/ww_mlp_regressor.sv
// Sequential MLP inference core: 11 features -> 3 ReLU hidden neurons -> linear Q7.14 score.
// state | meaning
// IDLE  | waiting for in_valid, features latched on accept
// HID   | one feature per cycle into all hidden accumulators
// OUT   | one hidden activation per cycle into the output accumulator
// DONE  | clamp and publish result, pulse out_valid
module ww_mlp_regressor
    import ww_mlp_pkg::*;
#(
    parameter int    H_SHIFT = ww_mlp_pkg::H_SHIFT,
    parameter w_ih_t W_IH    = ww_mlp_pkg::W_IH,
    parameter b_h_t  B_H     = ww_mlp_pkg::B_H,
    parameter w_ho_t W_HO    = ww_mlp_pkg::W_HO,
    parameter b_o_t  B_O     = ww_mlp_pkg::B_O
) (
    input  logic              clk,
    input  logic              rst_n,
    ww_mlp_regressor_if.slave bus
);

    localparam int X_W     = NUM_A * WIDTH_A;
    localparam int XI_W    = $clog2(X_W);
    localparam int J_W     = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int HID_MAX = (1 << HID_W) - 1;
    localparam int OUT_MAX = (1 << OUTWIDTH) - 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [OUTWIDTH-1:0] out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                load_h, en_h, load_o, en_o;

    logic [XI_W-1:0]           x_lsb;
    logic [WIDTH_A-1:0]        x_k;
    logic [J_W-1:0]            j_sel;
    logic signed [ACC_H_W-1:0] acc_h [N_HID];
    logic [HID_W-1:0]          h [N_HID];
    logic signed [ACC_O_W-1:0] acc_o;
    logic [OUTWIDTH-1:0]       out_clamp;

    assign x_lsb = XI_W'(idx_q) * XI_W'(WIDTH_A);
    assign x_k   = x_q[x_lsb +: WIDTH_A];
    assign j_sel = idx_q[J_W-1:0];

    for (genvar j = 0; j < N_HID; j++) begin : g_hid
        logic [ACC_H_W-1:0] sh;

        ww_mlp_mac #(.A_W(W_W), .B_W(WIDTH_A+1), .ACC_W(ACC_H_W)) u_mac (
            .clk        (clk),
            .rst_n      (rst_n),
            .load_i     (load_h),
            .load_val_i (ACC_H_W'($signed(B_H[j]))),
            .en_i       (en_h),
            .a_i        ($signed(W_IH[j][idx_q])),
            .b_i        ($signed({1'b0, x_k})),
            .acc_o      (acc_h[j])
        );

        // ReLU, scale down, then saturate into the unsigned activation width
        assign sh   = acc_h[j][ACC_H_W-1] ? '0 : ACC_H_W'(acc_h[j] >>> H_SHIFT);
        assign h[j] = (sh > ACC_H_W'(HID_MAX)) ? HID_W'(HID_MAX) : sh[HID_W-1:0];
    end

    ww_mlp_mac #(.A_W(W_W), .B_W(HID_W+1), .ACC_W(ACC_O_W)) u_mac_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_o),
        .load_val_i (ACC_O_W'($signed(B_O))),
        .en_i       (en_o),
        .a_i        ($signed(W_HO[j_sel])),
        .b_i        ($signed({1'b0, h[j_sel]})),
        .acc_o      (acc_o)
    );

    assign out_clamp = acc_o[ACC_O_W-1]           ? '0 :
                       (acc_o > ACC_O_W'(OUT_MAX)) ? OUTWIDTH'(OUT_MAX) : acc_o[OUTWIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        load_h      = 1'b0;
        en_h        = 1'b0;
        load_o      = 1'b0;
        en_o        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.inp;
                    load_h  = 1'b1;
                    idx_d   = '0;
                    state_d = HID;
                end
            end
            HID: begin
                en_h = 1'b1;
                if (idx_q == IDX_W'(NUM_A - 1)) begin
                    idx_d   = '0;
                    load_o  = 1'b1;
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OUT: begin
                en_o = 1'b1;
                if (idx_q == IDX_W'(N_HID - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                out_d       = out_clamp;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;

endmodule

// File: tb/tb_ww_mlp_regressor.sv
// Directed and reference-model bench for ww_mlp_regressor (unit-weight, negative and trained sets).
module tb_ww_mlp_regressor;

    localparam int XW = ww_mlp_pkg::NUM_A * ww_mlp_pkg::WIDTH_A;
    localparam int OW = ww_mlp_pkg::OUTWIDTH;

    localparam ww_mlp_pkg::w_ih_t T_IH   = {(ww_mlp_pkg::N_HID*ww_mlp_pkg::NUM_A){8'h01}};
    localparam ww_mlp_pkg::b_h_t  T_BH   = '0;
    localparam ww_mlp_pkg::w_ho_t T_HO_P = {ww_mlp_pkg::N_HID{8'h01}};
    localparam ww_mlp_pkg::w_ho_t T_HO_N = {ww_mlp_pkg::N_HID{8'hFF}};
    localparam ww_mlp_pkg::b_o_t  T_BO   = '0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ww_mlp_regressor_if bus_a ();
    ww_mlp_regressor_if bus_n ();
    ww_mlp_regressor_if bus_t ();

    ww_mlp_regressor #(.H_SHIFT(0), .W_IH(T_IH), .B_H(T_BH), .W_HO(T_HO_P), .B_O(T_BO))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    ww_mlp_regressor #(.H_SHIFT(0), .W_IH(T_IH), .B_H(T_BH), .W_HO(T_HO_N), .B_O(T_BO))
        dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));
    ww_mlp_regressor dut_t (.clk(clk), .rst_n(rst_n), .bus(bus_t));

    logic [2:0]    ov, bz;
    logic [OW-1:0] od [3];
    assign ov = {bus_t.out_valid, bus_n.out_valid, bus_a.out_valid};
    assign bz = {bus_t.busy, bus_n.busy, bus_a.busy};
    assign od[0] = bus_a.out;
    assign od[1] = bus_n.out;
    assign od[2] = bus_t.out;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic vld, input logic [XW-1:0] v);
        case (sel)
            0:       begin bus_a.in_valid = vld; bus_a.inp = v; end
            1:       begin bus_n.in_valid = vld; bus_n.inp = v; end
            default: begin bus_t.in_valid = vld; bus_t.inp = v; end
        endcase
    endtask

    // Called at a falling edge; returns at the falling edge where out_valid is first seen.
    task automatic run_req(input int sel, input logic [XW-1:0] v, input bit noise,
                           output logic [OW-1:0] res, output int lat, output int busy_n);
        logic [XW-1:0] junk;
        junk = {ww_mlp_pkg::NUM_A{4'hF}};
        drive(sel, 1'b1, v);
        @(negedge clk);
        lat    = 0;
        busy_n = 0;
        while (!ov[sel] && lat < 40) begin
            if (bz[sel]) busy_n++;
            if (noise && (lat == 5 || lat == 14)) drive(sel, 1'b1, junk);
            else                                  drive(sel, 1'b0, v);
            @(negedge clk);
            lat++;
        end
        drive(sel, 1'b0, v);
        res = od[sel];
    endtask

    function automatic logic [OW-1:0] ref_model(input logic [XW-1:0] v);
        longint acc, hh, o;
        int w;
        o = longint'($signed(ww_mlp_pkg::B_O));
        for (int j = 0; j < ww_mlp_pkg::N_HID; j++) begin
            acc = longint'($signed(ww_mlp_pkg::B_H[j]));
            for (int k = 0; k < ww_mlp_pkg::NUM_A; k++) begin
                w = $signed(ww_mlp_pkg::W_IH[j][k]);
                acc += longint'(w) * longint'(v[k*4 +: 4]);
            end
            hh = (acc < 0) ? 0 : (acc >>> ww_mlp_pkg::H_SHIFT);
            if (hh > 65535) hh = 65535;
            w = $signed(ww_mlp_pkg::W_HO[j]);
            o += longint'(w) * hh;
        end
        if (o < 0) o = 0;
        if (o > (1 << OW) - 1) o = (1 << OW) - 1;
        return OW'(o);
    endfunction

    initial begin
        logic [XW-1:0] v15, vmix, vr;
        logic [OW-1:0] res;
        int lat, bn, seen;

        v15 = {ww_mlp_pkg::NUM_A{4'hF}};
        for (int i = 0; i < ww_mlp_pkg::NUM_A; i++) vmix[i*4 +: 4] = 4'(i + 1);
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        drive(2, 1'b0, '0);

        repeat (3) @(negedge clk);
        chk("rst_busy", bz[0], 0);
        chk("rst_valid", ov[0], 0);
        chk("rst_out", od[0], 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_req(0, '0, 1'b0, res, lat, bn);
        chk("zero_lat", lat, 15);
        chk("zero_out", res, 0);

        run_req(0, v15, 1'b0, res, lat, bn);
        chk("f15_lat", lat, 15);
        chk("f15_out", res, 495);
        chk("f15_busy_cycles", bn, 15);
        chk("f15_busy_end", bz[0], 0);
        @(negedge clk);
        chk("f15_pulse", ov[0], 0);
        repeat (3) @(negedge clk);
        chk("f15_hold", od[0], 495);

        run_req(1, v15, 1'b0, res, lat, bn);
        chk("neg_lat", lat, 15);
        chk("neg_clamp", res, 0);

        run_req(0, vmix, 1'b1, res, lat, bn);
        chk("mix_lat", lat, 15);
        chk("mix_out", res, 198);
        run_req(0, vmix, 1'b0, res, lat, bn);
        chk("b2b_lat", lat, 15);
        chk("b2b_out", res, 198);

        @(negedge clk);
        drive(0, 1'b1, v15);
        @(negedge clk);
        drive(0, 1'b0, v15);
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bz[0], 0);
        chk("abort_out", od[0], 0);
        chk("abort_valid", ov[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ov[0]) seen++;
        end
        chk("abort_no_valid", seen, 0);

        run_req(0, vmix, 1'b0, res, lat, bn);
        chk("post_rst_lat", lat, 15);
        chk("post_rst_out", res, 198);

        run_req(2, v15, 1'b0, res, lat, bn);
        chk("trained_f15", res, ref_model(v15));
        for (int n = 0; n < 1000; n++) begin
            vr = XW'({$urandom(), $urandom()});
            run_req(2, vr, 1'b0, res, lat, bn);
            chk("trained_rand", res, ref_model(vr));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
